// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared types/constants for the hazard controller |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1
  } state_t;

  localparam int unsigned REG_AW_DEFAULT = 5;
  localparam int unsigned ZERO_REG       = 0;
  localparam int unsigned MC_CNT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_cmp : combinational load-use detector (EX load vs ID srcs)|
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  always_comb begin
    // r0 is hardwired zero, so a load targeting it never creates a dependency
    load_use = ex_memread
             && (ex_rd != REG_AW'(ZERO_REG))
             && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/flush control for the 5-stage pipeline  |
// | Optional counters via macro HAZARD_STATS_EN.  Revision 1.0       |
// +------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT,
  parameter int unsigned MC_LAT = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_mc_start,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mc_done,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [MC_CNT_W-1:0] MC_RELOAD = MC_CNT_W'(MC_LAT - 1);

  state_t              state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                load_use;
  logic                stall_evt;
  logic                flush_evt;

  hazard_cmp #(
    .REG_AW (REG_AW)
  ) u_hazard_cmp (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  always_comb begin
    state_d    = state_q;
    mc_cnt_d   = mc_cnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    mc_busy    = 1'b0;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    case (state_q)
      MC_WAIT: begin
        // the exit cycle still holds; RUN resumes after this edge
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        mc_busy = 1'b1;
        if (mc_done || (mc_cnt_q == '0)) begin
          state_d  = RUN;
          mc_cnt_d = '0;
        end else begin
          mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
        end
      end
      default: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_evt  = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          stall_evt  = 1'b1;
        end else if (id_mc_start) begin
          state_d  = MC_WAIT;
          mc_cnt_d = MC_RELOAD;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the enable (e) and synchronous-clear (Condep) inputs of the PC, IF/ID and ID/EX pipeline registers.
- Resolves load-use hazards, taken-branch redirects and multi-cycle execute operations (mul/div).
- Sits beside the ID stage; its outputs feed the pipeline-register control pins directly.

Parameters:
- REG_AW, 5, register-address width.
- MC_LAT, 32, cycles a multi-cycle op holds EX (2..255).
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Clrn  in  1  asynchronous active-low reset.
- id_rs  in  REG_AW  source register 1 of the ID instruction.
- id_rt  in  REG_AW  source register 2 of the ID instruction.
- id_uses_rt  in  1  ID instruction reads rt.
- id_mc_start  in  1  ID instruction is a multi-cycle op.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  EX destination register.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mc_done  in  1  multi-cycle unit finished early (optional early exit).
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID Condep.
- idex_en  out  1  ID/EX enable.
- idex_flush  out  1  ID/EX Condep (inserts bubble).
- mc_busy  out  1  controller in MC_WAIT.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  branch flush events.

Behaviour:
- One clock, Clk. Reset Clrn is asynchronous, active-low.
- State: 2-bit FSM {RUN, MC_WAIT} plus 8-bit down-counter mc_cnt.
- Reset: state=RUN, mc_cnt=0. Outputs then read pc_en=ifid_en=idex_en=1, flushes=0, mc_busy=0.
- Outputs are combinational from the registered state and the current inputs: zero-cycle reaction, taking effect at the next Clk edge.
- load_use = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).

RUN priority order, first match wins:
1. ex_branch_taken: pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=1, idex_en=1. Any load_use or id_mc_start in the same cycle is ignored because the ID instruction is squashed.
2. load_use: pc_en=0, ifid_en=0, idex_flush=1, idex_en=1. Exactly one bubble per hazard.
3. id_mc_start: outputs as normal flow. Next state MC_WAIT, mc_cnt <= MC_LAT-1.
4. Otherwise: all enables 1, flushes 0.

MC_WAIT:
- pc_en=ifid_en=idex_en=0, flushes=0, mc_busy=1. Front end and EX operand hold.
- mc_cnt decrements each cycle.
- Exit to RUN on the edge where mc_cnt==0 or mc_done=1.
- The exit cycle itself still holds. Total hold is MC_LAT cycles, fewer if mc_done arrives earlier.
- ex_branch_taken, load_use and id_mc_start are ignored in MC_WAIT.

Boundary rules:
- ex_rd==0 never stalls.
- mc_done in RUN is ignored.
- Clrn low mid-MC_WAIT returns to RUN immediately (asynchronously); mc_cnt=0.
- MC_LAT=2 gives a 2-cycle hold.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: stall_cnt increments on every RUN load_use stall cycle that is not overridden by a branch. flush_cnt increments on every RUN branch flush. Both saturate at all-ones and clear on Clrn.
- Undefined: no counter flops; stall_cnt and flush_cnt are tied to 0; ports are still present.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN=0, MC_WAIT=1)
  - REG_AW default
  - ZERO_REG constant
  - MC_CNT_W=8
- One sub-module, hazard_cmp: combinational load-use compare producing load_use. Instantiated once.

Test Plan:
1. Clrn=0 during MC_WAIT at mc_cnt=17 -> state=RUN and mc_busy=0 immediately. After release, with no hazard inputs, pc_en=ifid_en=idex_en=1.
2. ex_memread=1, ex_rd=8, id_rs=8 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle. Next cycle ex_memread=0 -> normal flow. stall_cnt=1 (HAZARD_STATS_EN).
3. ex_memread=1, ex_rd=0, id_rs=0 -> no stall. Also ex_rd=9, id_rt=9, id_uses_rt=0 -> no stall.
4. ex_branch_taken=1 with load_use=1 in the same cycle -> pc_en=1, ifid_flush=1, idex_flush=1. flush_cnt=1, stall_cnt unchanged.
5. id_mc_start=1 with MC_LAT=32 -> mc_busy high for exactly 32 cycles with all enables 0, then RUN. Repeat with mc_done pulsed on the 5th wait cycle -> exit after 5 cycles.
6. With HAZARD_STATS_EN and CNT_W=4: 20 stall cycles -> stall_cnt saturates at 15.
